shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//   Multi-cycle shift unit for the DLX execute stage (SLL/SRL/SRA and immediate forms).
//   Accepts an operand and a 0..31 shift amount, then performs one single-bit shift per cycle.
//   Reports completion with a one-cycle done pulse and holds the result until the next accepted request.
//   Replaces a barrel shifter where area matters; the ALU stalls while busy is high.
// PARAMETERS
//   WIDTH  32  datapath width in bits
//   AMT_W  5   shift-amount width; must satisfy 2**AMT_W >= WIDTH
// PORTS
//   clk     in   1       rising-edge clock
//   rst_n   in   1       asynchronous active-low reset
//   start   in   1       request strobe; sampled only in IDLE
//   right   in   1       1 = shift right, 0 = shift left
//   arith   in   1       1 = arithmetic right shift (sign-fill); ignored when right=0
//   amount  in   AMT_W   shift count, 0..WIDTH-1
//   D_in    in   WIDTH   operand
//   busy    out  1       high whenever state != IDLE
//   done    out  1       one-cycle pulse; result valid on D_out
//   D_out   out  WIDTH   result register; holds value until the next accepted start
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, data reg=0, count=0, busy=0, done=0, D_out=0.
//     Reset mid-operation abandons the shift; no done pulse is produced.
//   FSM states: IDLE, SHIFT, DONE.
//   IDLE:  start=1 latches D_in->data reg, amount->count, right and arith->mode regs.
//          Next state is SHIFT if amount!=0, otherwise DONE.
//   SHIFT: each cycle, data reg <= one-bit shift of data reg; count <= count-1.
//          When count==1, next state is DONE.
//   DONE:  done=1 for exactly one cycle, then next state is IDLE.
//   One-bit shift rules:
//     left        -> {d[W-2:0],1'b0}
//     right logic -> {1'b0,d[W-1:1]}
//     right arith -> {d[W-1],d[W-1:1]}
//   Mode (right, arith) is frozen at accept; input changes during busy have no effect.
//   Latency: start is sampled in cycle 0; done is high in cycle amount+1.
//     amount=0 gives done in cycle 1.
//   D_out is driven from the data register, so it changes during SHIFT.
//     D_out is guaranteed valid only while done=1 and afterwards until the next accepted start.
//   start while busy (SHIFT or DONE): ignored, not queued; the requester re-issues it in IDLE.
//   Back-to-back operation: earliest new accept is the cycle after done, giving a minimum period of amount+2.
//   amount >= WIDTH: out of contract. The implementation still counts down the full amount.
//     Result: all zeros for logical shifts, all sign bits for arithmetic shifts.
//   busy and done are registered decodes of state; neither output is combinational from inputs.
// TESTING
//   1. Reset, then start D_in=0x0000_0001, right=0, amount=4.
//      -> busy for cycles 1-5; done in cycle 5; D_out=0x0000_0010.
//   2. D_in=0x8000_00F0, right=1, arith=1, amount=4.
//      -> done in cycle 5; D_out=0xF800_000F. Same request with arith=0 -> D_out=0x0800_000F.
//   3. amount=0, D_in=0xDEAD_BEEF.
//      -> done in cycle 1; D_out=0xDEAD_BEEF; busy high only in cycle 1.
//   4. amount=31, left shift, D_in=0xFFFF_FFFF.
//      -> done in cycle 32; D_out=0x8000_0000. A second start pulsed in cycle 10 is ignored.
//      -> Exactly one done pulse is produced.
//   5. Start amount=8, deassert rst_n in cycle 3.
//      -> busy=0, done=0, D_out=0 immediately; no done pulse follows.
//      -> A fresh start after reset completes normally.
//   6. Back-to-back: request A (amount=2) followed by request B (start held high).
//      -> A's done in cycle 3; B accepted in cycle 4; B's done in cycle 4+amount_B+1.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/result bundle for the multi-cycle shift unit
//
// Purpose: groups the request strobe, operand, mode and result signals of
// shift_sequencer so the execute stage connects them as one bundle.
//
// Signals:
//   start   request strobe, only honoured while the unit is idle
//   right   1 = shift right, 0 = shift left
//   arith   1 = sign-fill on right shifts (ignored for left shifts)
//   amount  shift count
//   D_in    operand
//   busy    unit is not idle; the requester stalls while high
//   done    one-cycle completion pulse
//   D_out   result register
//
// Modports:
//   master  requester side (drives the request, observes status/result)
//   slave   shift unit side
interface shift_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) ();

  logic             start;
  logic             right;
  logic             arith;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] D_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D_out;

  modport master (
    output start,
    output right,
    output arith,
    output amount,
    output D_in,
    input  busy,
    input  done,
    input  D_out
  );

  modport slave (
    input  start,
    input  right,
    input  arith,
    input  amount,
    input  D_in,
    output busy,
    output done,
    output D_out
  );

endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle one-bit-per-cycle shift unit (SLL/SRL/SRA)
//
// Purpose: area-lean replacement for a barrel shifter in the DLX execute
// stage. A request is accepted in IDLE, the operand is then shifted by one
// bit per cycle until the count is exhausted, and a one-cycle done pulse
// marks the result on D_out. The result is held until the next accepted
// request.
//
// Parameters:
//   WIDTH  datapath width
//   AMT_W  shift-amount width (2**AMT_W must cover WIDTH-1)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    shift_sequencer_if.slave (start/right/arith/amount/D_in in,
//          busy/done/D_out out)
//
// Timing: start sampled in cycle 0, done high in cycle amount+1, busy high
// in cycles 1..amount+1. busy and done are registers, never combinational
// from inputs.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_sequencer_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] count_q;
  logic             mode_right_q;
  logic             mode_arith_q;
  logic             busy_q;
  logic             done_q;

  // One-bit shift of the working register. The fill bit is only ever the
  // sign bit for an arithmetic right shift; everything else fills with zero.
  logic [WIDTH-1:0] shifted;
  logic             fill_bit;

  always_comb begin
    fill_bit = mode_right_q & mode_arith_q & data_q[WIDTH-1];
    shifted  = data_q;
    if (mode_right_q) begin
      shifted = {fill_bit, data_q[WIDTH-1:1]};
    end else begin
      shifted = {data_q[WIDTH-2:0], 1'b0};
    end
  end

  // Single state machine; busy/done are loaded with the decode of the
  // next state so they line up exactly with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      data_q       <= '0;
      count_q      <= '0;
      mode_right_q <= 1'b0;
      mode_arith_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            data_q       <= bus.D_in;
            count_q      <= bus.amount;
            mode_right_q <= bus.right;
            // arith has no meaning for left shifts; drop it at accept
            mode_arith_q <= bus.right & bus.arith;
            busy_q       <= 1'b1;
            if (bus.amount != '0) begin
              state <= SHIFT;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end

        SHIFT: begin
          // Requests arriving here are dropped, not queued.
          data_q  <= shifted;
          count_q <= count_q - 1'b1;
          // count is never zero in SHIFT; the <= guards against a corrupted
          // count wedging the unit.
          if (count_q <= AMT_W'(1)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // D_out tracks the working register, so it moves during SHIFT and is only
  // meaningful from the done pulse until the next accept.
  assign bus.D_out = data_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer
module tb_shift_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  shift_sequencer_if #(.WIDTH(32), .AMT_W(5)) bus ();

  shift_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request (sampled by the next rising edge = end of cycle 0),
  // then watch cycles 1..amount+3. glitch>0 pulses a conflicting request
  // in that cycle, which must be ignored.
  task automatic run_op(input string tag, input logic [31:0] d, input logic r,
                        input logic a, input logic [4:0] amt,
                        input logic [31:0] exp_q, input int glitch);
    int          exp_cycle;
    int          dones;
    int          first;
    int          busy_bad;
    logic [31:0] q;
    exp_cycle  = int'(amt) + 1;
    bus.D_in   = d;
    bus.right  = r;
    bus.arith  = a;
    bus.amount = amt;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    dones    = 0;
    first    = 0;
    busy_bad = 0;
    q        = '0;
    for (int c = 1; c <= exp_cycle + 2; c++) begin
      @(negedge clk);
      if (c == glitch) begin
        bus.start  = 1'b1;
        bus.D_in   = 32'h1234_5678;
        bus.amount = 5'd1;
        bus.right  = ~r;
        bus.arith  = ~a;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        dones++;
        if (first == 0) begin
          first = c;
          q     = bus.D_out;
        end
      end
      if (bus.busy !== (c <= exp_cycle)) busy_bad++;
    end
    check({tag, "_done_cycle"}, first, exp_cycle);
    check({tag, "_dout"}, q, exp_q);
    check({tag, "_done_pulses"}, dones, 1);
    check({tag, "_busy_window"}, busy_bad, 0);
    check({tag, "_dout_hold"}, bus.D_out, exp_q);
  endtask

  initial begin
    int dones;
    int done_a;
    int done_b;
    logic [31:0] q_a;
    logic [31:0] q_b;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.right  = 1'b0;
    bus.arith  = 1'b0;
    bus.amount = '0;
    bus.D_in   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_dout", bus.D_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    run_op("sll4",      32'h0000_0001, 1'b0, 1'b0, 5'd4,  32'h0000_0010, 0);
    run_op("sra4",      32'h8000_00F0, 1'b1, 1'b1, 5'd4,  32'hF800_000F, 0);
    run_op("srl4",      32'h8000_00F0, 1'b1, 1'b0, 5'd4,  32'h0800_000F, 0);
    run_op("amt0",      32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0,  32'hDEAD_BEEF, 0);
    run_op("sll31_ign", 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd31, 32'h8000_0000, 10);
    run_op("srl31",     32'h8000_0000, 1'b1, 1'b0, 5'd31, 32'h0000_0001, 0);
    run_op("sra31",     32'h8000_0000, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 0);
    run_op("sll_arith", 32'h4000_0001, 1'b0, 1'b1, 5'd1,  32'h8000_0002, 0);

    // Reset in cycle 3 of an 8-bit shift
    bus.D_in   = 32'hA5A5_0000;
    bus.right  = 1'b0;
    bus.arith  = 1'b0;
    bus.amount = 5'd8;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_done", bus.done, 0);
    check("rst_mid_dout", bus.D_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("rst_mid_no_done", dones, 0);
    run_op("after_rst", 32'h0000_00FF, 1'b0, 1'b0, 5'd8, 32'h0000_FF00, 0);

    // Back-to-back: A (amount 2) then B with start held high
    bus.D_in   = 32'h0000_0003;
    bus.right  = 1'b0;
    bus.arith  = 1'b0;
    bus.amount = 5'd2;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.D_in   = 32'hF000_0000;
    bus.right  = 1'b1;
    bus.arith  = 1'b1;
    bus.amount = 5'd3;
    done_a = 0;
    done_b = 0;
    q_a    = '0;
    q_b    = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 5) bus.start = 1'b0;
      if (bus.done) begin
        if (done_a == 0) begin
          done_a = c;
          q_a    = bus.D_out;
        end else if (done_b == 0) begin
          done_b = c;
          q_b    = bus.D_out;
        end
      end
    end
    bus.start = 1'b0;
    check("b2b_a_cycle", done_a, 3);
    check("b2b_a_dout", q_a, 32'h0000_000C);
    check("b2b_b_cycle", done_b, 8);
    check("b2b_b_dout", q_b, 32'hFE00_0000);
    check("b2b_idle", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
